sha256_multiblock_core: RTL and testbench
=========================================

# sha256_multiblock_core

Parametrised SHA-256 compression engine that processes a stream of pre-padded 512-bit blocks, chaining the hash state across blocks of one message and emitting the 256-bit digest after the last block. The unroll factor (rounds per clock) is a parameter, so one RTL serves both area-oriented and throughput-oriented builds. The message schedule is a 16-word sliding window rather than a 64-word array. It sits between the padding/packing front end and the digest consumer, using a valid/ready block handshake.

## Interface
- ROUNDS_PER_CYCLE, default 2: SHA-256 rounds per clock. Legal values are 1, 2, 4, 8; any other value is an elaboration error.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- block_valid  in  1  block_data/first_block/last_block are valid.
- block_ready  out  1  core can accept a block (IDLE).
- block_data  in  512  pre-padded block; W0 = [511:480], W15 = [31:0].
- first_block  in  1  block starts a message; chaining state = IV.
- last_block  in  1  block ends a message; publish digest.
- digest_valid  out  1  one-cycle pulse, digest is new.
- digest  out  256  H0 in [255:224] … H7 in [31:0]; holds until the next publish.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE:
  - block_ready = 1 while reset is low.
  - On a handshake edge (block_valid & block_ready):
    - Load the window with W0..W15.
    - Load the chain register with IV if first_block = 1; otherwise keep it.
    - Load a..h from the same (possibly just-selected) chain value.
    - Latch last_block into last_q.
    - Clear rnd, go to ROUND.
- ROUND:
  - Each edge performs R = ROUNDS_PER_CYCLE rounds t = rnd..rnd+R-1 with K[t] from a 64-entry constant ROM.
  - The window shifts by R and appends R new words: Wn = σ1(Wn-2) + Wn-7 + σ0(Wn-15) + Wn-16 mod 2^32.
  - New words within a cycle chain combinationally when R > 2.
  - rnd += R. After the edge where rnd reaches 64, go to FINAL.
- FINAL, one edge:
  - chain[i] <= chain[i] + {a..h}[i] mod 2^32.
  - If last_q: digest <= sum and digest_valid <= 1.
  - Go to IDLE.
- Function definitions:
  - σ0 = ror7 ^ ror18 ^ shr3
  - σ1 = ror17 ^ ror19 ^ shr10
  - Σ0 = ror2 ^ ror13 ^ ror22
  - Σ1 = ror6 ^ ror11 ^ ror25
  - Ch = (e&f) ^ (~e&g)
  - Maj = (a&b) ^ (a&c) ^ (b&c)
- All additions wrap modulo 2^32; no carry leaves a word.
- IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- first_block = 1 with last_block = 1: single-block message.
- first_block = 0 on the very first block after reset: chains from IV, because reset loads IV.
- block_valid while busy: ignored. No queueing; the source must hold until block_ready.
- Inputs are sampled only on the handshake edge.
- Padding is not checked; the core hashes whatever it receives.

## Timing
- Reset (asynchronous, immediate) forces:
  - state = IDLE, chain = IV, digest = 0, digest_valid = 0, busy = 0, rnd = 0, last_q = 0, window and a..h = 0.
  - block_ready = 0 while reset is high; 1 in the first cycle after deassertion.
- Reset mid-block or mid-message aborts the operation. No digest_valid pulse is produced, and the next block must carry first_block = 1 to be meaningful.
- Handshake at edge E0:
  - ROUND spans edges E1..E(64/R).
  - FINAL is edge E(64/R+1).
  - digest_valid is high for exactly the one cycle following E(64/R+1); block_ready is high in that same cycle.
- Throughput: one block per 64/R + 2 cycles (R=1: 66, R=2: 34, R=4: 18, R=8: 10).
- Back-to-back blocks: a block offered in the digest_valid cycle is accepted on that cycle's edge, giving zero bubbles beyond FINAL.
- busy is high from the cycle after E0 through the cycle containing E(64/R+1).

## Test plan
- Single-block "abc": W0 = 61626380, W1–W14 = 0, W15 = 00000018, first = last = 1. Required: digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid exactly 64/R+2 cycles after the handshake, for R = 1, 2, 4, 8.
- Empty message: W0 = 80000000, rest 0. Required: digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": first block with first = 1, last = 0, then the second block with first = 0, last = 1. Required: no digest_valid after block 1, and after block 2 digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Back-to-back "abc" twice, both first = last = 1, with the second offered in the digest_valid cycle. Required: two identical "abc" digests 64/R+2 cycles apart (no chain leakage). block_valid held during busy is not accepted early.
- Reset asserted at ROUND cycle 10 of block 1 of the two-block message. Required: outputs immediately return to reset values and no digest_valid pulse occurs; a following "abc" (first = 1) yields the correct "abc" digest.

Source files
------------

// File: rtl/sha256_multiblock_core.sv
// SHA-256 compression engine: chains hash state across pre-padded 512-bit
// blocks, runs ROUNDS_PER_CYCLE rounds per clock, and publishes the digest
// after the block flagged last_block.
module sha256_multiblock_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block_data,
  input  logic         first_block,
  input  logic         last_block,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic         busy
);

  localparam int unsigned R     = ROUNDS_PER_CYCLE;
  localparam int unsigned RND_W = 7;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("sha256_multiblock_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  state_t                 state_q;
  logic [RND_W-1:0]       rnd_q;
  logic [RND_W-1:0]       rnd_d;
  logic                   last_q;
  logic                   busy_q;
  logic                   ready_q;
  logic                   dvalid_q;
  logic [255:0]           digest_q;
  logic [31:0]            chain_q [8];
  logic [31:0]            wv_q    [8];
  logic [31:0]            w_q     [16];
  logic [31:0]            wv_d    [8];
  logic [31:0]            w_d     [16];
  logic [31:0]            sum_d   [8];

  // Ready is a registered flag, forced low while reset is held
  assign block_ready  = ready_q & ~reset;
  assign busy         = busy_q;
  assign digest_valid = dvalid_q;
  assign digest       = digest_q;
  assign rnd_d        = rnd_q + RND_W'(R);

  // R rounds per clock plus schedule expansion; new words chain within the cycle
  always_comb begin
    logic [31:0] ext [16+R];
    logic [31:0] st  [8];
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < int'(R); j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
    for (int i = 0; i < 8; i++) st[i] = wv_q[i];
    for (int j = 0; j < int'(R); j++) begin
      t1 = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6]))
         + K[6'(rnd_q) + 6'(j)] + ext[j];
      t2 = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
      st[7] = st[6];
      st[6] = st[5];
      st[5] = st[4];
      st[4] = st[3] + t1;
      st[3] = st[2];
      st[2] = st[1];
      st[1] = st[0];
      st[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) wv_d[i] = st[i];
    for (int i = 0; i < 16; i++) w_d[i] = ext[i+R];
  end

  // Feed-forward sum of chaining value and working variables
  always_comb begin
    for (int i = 0; i < 8; i++) sum_d[i] = chain_q[i] + wv_q[i];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rnd_q    <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      dvalid_q <= 1'b0;
      digest_q <= '0;
      for (int i = 0; i < 8; i++) begin
        chain_q[i] <= IV[i];
        wv_q[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      dvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (block_valid) begin
            for (int i = 0; i < 16; i++) w_q[i] <= block_data[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              chain_q[i] <= first_block ? IV[i] : chain_q[i];
              wv_q[i]    <= first_block ? IV[i] : chain_q[i];
            end
            last_q  <= last_block;
            rnd_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          wv_q  <= wv_d;
          w_q   <= w_d;
          rnd_q <= rnd_d;
          if (rnd_d == RND_W'(64)) state_q <= S_FINAL;
        end
        S_FINAL: begin
          chain_q <= sum_d;
          if (last_q) begin
            digest_q <= {sum_d[0], sum_d[1], sum_d[2], sum_d[3],
                         sum_d[4], sum_d[5], sum_d[6], sum_d[7]};
            dvalid_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Self-checking bench for sha256_multiblock_core: table of known-answer
// blocks, digest scoreboard, mid-message reset, back-to-back and
// alternate unroll factors.
module tb_sha256_multiblock_core;

  localparam int unsigned R   = 2;
  localparam int          LAT = 64 / R + 1;

  localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] H_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         reset;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         first_block;
  logic         last_block;
  logic         digest_valid;
  logic [255:0] digest;
  logic         busy;

  logic         a_valid [3];
  logic         a_ready [3];
  logic         a_dv    [3];
  logic         a_busy  [3];
  logic [255:0] a_dig   [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_dv    = 0;
  int n_push  = 0;
  int last_dv_cyc = 0;
  logic [255:0] exp_q [$];
  int           dv_cyc [$];

  typedef struct {
    string        name;
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [255:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  sha256_multiblock_core #(.ROUNDS_PER_CYCLE(R)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .block_data   (block_data),
    .first_block  (first_block),
    .last_block   (last_block),
    .digest_valid (digest_valid),
    .digest       (digest),
    .busy         (busy)
  );

  for (genvar k = 0; k < 3; k++) begin : g_alt
    localparam int unsigned RK = (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    sha256_multiblock_core #(.ROUNDS_PER_CYCLE(RK)) u_alt (
      .clk          (clk),
      .reset        (reset),
      .block_valid  (a_valid[k]),
      .block_ready  (a_ready[k]),
      .block_data   (block_data),
      .first_block  (1'b1),
      .last_block   (1'b1),
      .digest_valid (a_dv[k]),
      .digest       (a_dig[k]),
      .busy         (a_busy[k])
    );
  end

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard: every digest_valid pulse must match the oldest expected digest
  always @(posedge clk) begin
    #1;
    if (!reset && digest_valid === 1'b1) begin
      n_dv++;
      last_dv_cyc = cyc;
      dv_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_digest: got %h required no pulse", digest);
      end else begin
        check_vec("digest", digest, exp_q.pop_front());
      end
    end
  end

  // Offer one block and hold it until accepted; returns the handshake cycle
  task automatic send_block(input logic [511:0] d, input logic f, input logic l,
                            input logic [255:0] req, output int hs);
    block_data  = d;
    first_block = f;
    last_block  = l;
    block_valid = 1'b1;
    hs = -1;
    for (int n = 0; n < 200; n++) begin
      if (block_ready === 1'b1) begin
        if (l) begin
          exp_q.push_back(req);
          n_push++;
        end
        @(posedge clk);
        #1;
        hs = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    block_valid = 1'b0;
    if (hs < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: got no block_ready required ready within 200 cycles");
    end
  endtask

  // Wait until every expected digest has been seen
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending digests required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   hs, hs1, hs2, n;
    logic [255:0] last_pub;

    vecs[0] = '{name: "abc",   data: B_ABC,   first: 1'b1, last: 1'b1, exp: H_ABC};
    vecs[1] = '{name: "empty", data: B_EMPTY, first: 1'b1, last: 1'b1, exp: H_EMPTY};
    vecs[2] = '{name: "two_b1", data: B_TWO1, first: 1'b1, last: 1'b0, exp: 256'h0};
    vecs[3] = '{name: "two_b2", data: B_TWO2, first: 1'b0, last: 1'b1, exp: H_TWO};

    block_valid = 1'b0;
    block_data  = '0;
    first_block = 1'b0;
    last_block  = 1'b0;
    for (int k = 0; k < 3; k++) a_valid[k] = 1'b0;
    reset = 1'b1;
    last_pub = '0;

    repeat (3) @(posedge clk);
    #1;
    check_int("rst_ready", int'(block_ready), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_dvalid", int'(digest_valid), 0);
    check_vec("rst_digest", digest, 256'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_int("ready_after_rst", int'(block_ready), 1);
    @(posedge clk);
    #1;

    // Known-answer table, including the two-block chained message
    for (int i = 0; i < 4; i++) begin
      send_block(vecs[i].data, vecs[i].first, vecs[i].last, vecs[i].exp, hs);
      check_int({"busy_", vecs[i].name}, int'(busy), 1);
      if (vecs[i].last) begin
        drain();
        check_int({"latency_", vecs[i].name}, last_dv_cyc - hs, LAT);
        last_pub = vecs[i].exp;
      end else begin
        check_vec({"hold_", vecs[i].name}, digest, last_pub);
      end
    end

    // Back-to-back: second block offered during busy, accepted in the digest_valid cycle
    dv_cyc.delete();
    send_block(B_ABC, 1'b1, 1'b1, H_ABC, hs1);
    send_block(B_ABC, 1'b1, 1'b1, H_ABC, hs2);
    drain();
    check_int("b2b_accept_gap", hs2 - hs1, LAT + 1);
    check_int("b2b_pulses", dv_cyc.size(), 2);
    if (dv_cyc.size() == 2) check_int("b2b_digest_gap", dv_cyc[1] - dv_cyc[0], LAT + 1);

    // Reset during ROUND of the first block of a two-block message
    send_block(B_TWO1, 1'b1, 1'b0, 256'h0, hs);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_int("midrst_ready", int'(block_ready), 0);
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_dvalid", int'(digest_valid), 0);
    check_vec("midrst_digest", digest, 256'h0);
    @(negedge clk);
    reset = 1'b0;
    n = n_dv;
    repeat (40) @(posedge clk);
    #1;
    check_int("midrst_no_pulse", n_dv - n, 0);
    send_block(B_ABC, 1'b1, 1'b1, H_ABC, hs);
    drain();
    check_int("midrst_abc_latency", last_dv_cyc - hs, LAT);

    // First block after reset with first_block=0 still starts from IV
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_block(B_EMPTY, 1'b0, 1'b1, H_EMPTY, hs);
    drain();

    check_int("digest_count", n_dv, n_push);

    // Alternate unroll factors R = 1, 4, 8 on "abc"
    for (int k = 0; k < 3; k++) begin
      block_data = B_ABC;
      a_valid[k] = 1'b1;
      n = 0;
      while (a_ready[k] !== 1'b1 && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      @(posedge clk);
      #1;
      a_valid[k] = 1'b0;
      n = 0;
      while (a_dv[k] !== 1'b1 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      check_int($sformatf("alt%0d_latency", k), n, 64 / ((k == 0) ? 1 : ((k == 1) ? 4 : 8)) + 1);
      check_vec($sformatf("alt%0d_digest", k), a_dig[k], H_ABC);
      @(posedge clk);
      #1;
      check_int($sformatf("alt%0d_pulse_width", k), int'(a_dv[k]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
